ps2_key_port_arbiter: RTL and testbench

PS2_KEY_PORT_ARBITER -- requirements
Module: ps2_key_port_arbiter

---
 rtl/ps2_key_port_arbiter.sv | 123 ++++++++++++
 tb/tb_ps2_key_port_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_port_arbiter.sv
// Two-port round-robin arbiter in front of the shared PS/2 key-state memory.
// One read in flight at a time; the memory registers its address, so each read takes two cycles.
module ps2_key_port_arbiter #(
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_i,
    input  logic              req1_i,
    input  logic [ADDR_W-1:0] addr0_i,
    input  logic [ADDR_W-1:0] addr1_i,
    output logic              gnt0_o,
    output logic              gnt1_o,
    output logic [DATA_W-1:0] rdata0_o,
    output logic [DATA_W-1:0] rdata1_o,
    output logic              rvalid0_o,
    output logic              rvalid1_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic [DATA_W-1:0] mem_data_i,
    output logic              busy_o
);

    typedef enum logic [1:0] {
        StIdle,
        StAddr,
        StRead
    } state_e;

    state_e              state_q, state_d;
    // Last-served port; it also names the owner of the read in flight.
    logic                last_q, last_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [1:0]          gnt_q, gnt_d;
    logic [1:0]          rvalid_q, rvalid_d;
    logic [DATA_W-1:0]   rdata0_q, rdata0_d;
    logic [DATA_W-1:0]   rdata1_q, rdata1_d;

    logic                any_req;
    logic                pick1;
    logic                grant;

    assign any_req = req0_i | req1_i;
    // On a tie the port that was not served last wins.
    assign pick1   = req1_i & (~req0_i | ~last_q);

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        mem_addr_d = mem_addr_q;
        gnt_d      = 2'b00;
        rvalid_d   = 2'b00;
        rdata0_d   = rdata0_q;
        rdata1_d   = rdata1_q;
        grant      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (any_req) begin
                    grant   = 1'b1;
                    state_d = StAddr;
                end
            end
            StAddr: begin
                state_d = StRead;
            end
            StRead: begin
                if (last_q) begin
                    rdata1_d = mem_data_i;
                    rvalid_d = 2'b10;
                end else begin
                    rdata0_d = mem_data_i;
                    rvalid_d = 2'b01;
                end
                if (any_req) begin
                    grant   = 1'b1;
                    state_d = StAddr;
                end else begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (grant) begin
            last_d     = pick1;
            mem_addr_d = pick1 ? addr1_i : addr0_i;
            gnt_d      = pick1 ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            last_q     <= 1'b1;
            mem_addr_q <= '0;
            gnt_q      <= 2'b00;
            rvalid_q   <= 2'b00;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            mem_addr_q <= mem_addr_d;
            gnt_q      <= gnt_d;
            rvalid_q   <= rvalid_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
        end
    end

    assign gnt0_o     = gnt_q[0];
    assign gnt1_o     = gnt_q[1];
    assign rvalid0_o  = rvalid_q[0];
    assign rvalid1_o  = rvalid_q[1];
    assign rdata0_o   = rdata0_q;
    assign rdata1_o   = rdata1_q;
    assign mem_addr_o = mem_addr_q;
    assign busy_o     = (state_q != StIdle);

endmodule

// File: tb/tb_ps2_key_port_arbiter.sv
// Bench for ps2_key_port_arbiter: vector table, directed corner sequences and a random run
// checked by a cycle model with per-port expected-data queues.
module tb_ps2_key_port_arbiter;

    localparam int unsigned AW = 9;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req0 = 1'b0, req1 = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic          gnt0, gnt1, rvalid0, rvalid1, busy;
    logic [DW-1:0] rdata0, rdata1;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data = '0;

    logic [DW-1:0] key_mem [256];

    ps2_key_port_arbiter #(
        .ADDR_W(AW),
        .DATA_W(DW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_i     (req0),
        .req1_i     (req1),
        .addr0_i    (addr0),
        .addr1_i    (addr1),
        .gnt0_o     (gnt0),
        .gnt1_o     (gnt1),
        .rdata0_o   (rdata0),
        .rdata1_o   (rdata1),
        .rvalid0_o  (rvalid0),
        .rvalid1_o  (rvalid1),
        .mem_addr_o (mem_addr),
        .mem_data_i (mem_data),
        .busy_o     (busy)
    );

    always #5 clk = ~clk;

    // Key-state memory with a registered address.
    always @(posedge clk) mem_data <= key_mem[mem_addr[7:0]];

    int checks = 0;
    int errors = 0;
    int reads  = 0;

    logic [DW-1:0] exp_q0 [$];
    logic [DW-1:0] exp_q1 [$];

    // Reference model state (0 idle, 1 addr, 2 read).
    int            m_state = 0;
    int            m_last  = 1;
    logic [AW-1:0] m_mem_addr = '0;
    logic [1:0]    m_gnt = 2'b00;
    logic [1:0]    m_rv  = 2'b00;
    logic [DW-1:0] m_rd0 = '0, m_rd1 = '0;
    int            wait0 = 0, wait1 = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        logic [1:0] nrv;
        int         w;
        if (!rst) begin
            m_state = 0; m_last = 1; m_mem_addr = '0; m_gnt = 2'b00; m_rv = 2'b00;
            m_rd0 = '0; m_rd1 = '0; wait0 = 0; wait1 = 0;
            exp_q0.delete();
            exp_q1.delete();
        end
        chk("gnt0", 64'(gnt0), 64'(m_gnt[0]));
        chk("gnt1", 64'(gnt1), 64'(m_gnt[1]));
        chk("gnt_overlap", 64'(gnt0 & gnt1), 64'(0));
        chk("busy", 64'(busy), 64'(m_state != 0));
        chk("mem_addr", 64'(mem_addr), 64'(m_mem_addr));
        chk("rvalid0", 64'(rvalid0), 64'(m_rv[0]));
        chk("rvalid1", 64'(rvalid1), 64'(m_rv[1]));
        if (rvalid0 === 1'b1) begin
            checks++;
            if (exp_q0.size() == 0) begin
                errors++;
                $display("FAIL rvalid0_unexpected: got pulse expected none at %0t", $time);
            end else begin
                m_rd0 = exp_q0.pop_front();
                reads++;
            end
        end
        if (rvalid1 === 1'b1) begin
            checks++;
            if (exp_q1.size() == 0) begin
                errors++;
                $display("FAIL rvalid1_unexpected: got pulse expected none at %0t", $time);
            end else begin
                m_rd1 = exp_q1.pop_front();
                reads++;
            end
        end
        chk("rdata0", 64'(rdata0), 64'(m_rd0));
        chk("rdata1", 64'(rdata1), 64'(m_rd1));

        if (rst) begin
            wait0 = (req0 && !gnt0) ? wait0 + 1 : 0;
            wait1 = (req1 && !gnt1) ? wait1 + 1 : 0;
            if (req0) chk("wait0_over_4", 64'(wait0 > 4), 64'(0));
            if (req1) chk("wait1_over_4", 64'(wait1 > 4), 64'(0));

            nrv   = 2'b00;
            m_gnt = 2'b00;
            if (m_state == 2) nrv = (m_last == 1) ? 2'b10 : 2'b01;
            if (m_state != 1 && (req0 || req1)) begin
                w = (req1 && (!req0 || m_last == 0)) ? 1 : 0;
                if (w == 1) begin
                    m_mem_addr = addr1;
                    exp_q1.push_back(key_mem[addr1[7:0]]);
                    m_gnt = 2'b10;
                end else begin
                    m_mem_addr = addr0;
                    exp_q0.push_back(key_mem[addr0[7:0]]);
                    m_gnt = 2'b01;
                end
                m_last  = w;
                m_state = 1;
            end else if (m_state == 1) begin
                m_state = 2;
            end else begin
                m_state = 0;
            end
            m_rv = nrv;
        end
    end

    typedef struct {
        logic          r0;
        logic          r1;
        logic [AW-1:0] a0;
        logic [AW-1:0] a1;
        logic [1:0]    gnt;
        logic [AW-1:0] maddr;
        logic [DW-1:0] rdata;
    } vec_t;

    vec_t vecs [6];

    task automatic wait_any_gnt(output logic ok);
        ok = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (gnt0 === 1'b1 || gnt1 === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        chk("gnt_timeout", 64'(ok), 64'(1));
    endtask

    initial begin
        logic          ok;
        logic [7:0]    b;
        logic          g0, g1;
        int            lat, gc, vc, last_at, cyc, target;
        int            order [$];
        int            at [$];

        for (int i = 0; i < 256; i++) begin
            b = i[7:0];
            key_mem[i] = {b, 8'h00, ~b, 8'h00};
        end
        key_mem[8'h61] = 32'h0000_0001;

        // Pointer starts at "port 1 served last".
        vecs[0] = '{1'b1, 1'b0, 9'h061, 9'h000, 2'b01, 9'h061, 32'h0000_0001};
        vecs[1] = '{1'b1, 1'b1, 9'h041, 9'h042, 2'b10, 9'h042, 32'h4200_BD00};
        vecs[2] = '{1'b1, 1'b1, 9'h041, 9'h042, 2'b01, 9'h041, 32'h4100_BE00};
        vecs[3] = '{1'b0, 1'b1, 9'h000, 9'h1FF, 2'b10, 9'h1FF, 32'hFF00_0000};
        vecs[4] = '{1'b0, 1'b1, 9'h000, 9'h130, 2'b10, 9'h130, 32'h3000_CF00};
        vecs[5] = '{1'b1, 1'b1, 9'h007, 9'h108, 2'b01, 9'h007, 32'h0700_F800};

        repeat (3) @(posedge clk);
        #3 rst = 1'b1;

        for (int i = 0; i < 6; i++) begin
            tick();
            req0 = vecs[i].r0; req1 = vecs[i].r1;
            addr0 = vecs[i].a0; addr1 = vecs[i].a1;
            wait_any_gnt(ok);
            chk("vec_gnt", 64'({gnt1, gnt0}), 64'(vecs[i].gnt));
            chk("vec_mem_addr", 64'(mem_addr), 64'(vecs[i].maddr));
            req0 = 1'b0; req1 = 1'b0;
            lat = 0;
            for (int k = 1; k <= 8; k++) begin
                tick();
                if (rvalid0 === 1'b1 || rvalid1 === 1'b1) begin
                    lat = k;
                    break;
                end
            end
            chk("vec_latency", 64'(lat), 64'(2));
            chk("vec_rvalid", 64'({rvalid1, rvalid0}), 64'(vecs[i].gnt));
            chk("vec_rdata", 64'(vecs[i].gnt[1] ? rdata1 : rdata0), 64'(vecs[i].rdata));
            tick();
        end

        // Reset while the read is in the address phase.
        req0 = 1'b1; addr0 = 9'h061;
        wait_any_gnt(ok);
        chk("rst_pre_gnt0", 64'(gnt0), 64'(1));
        req0 = 1'b0;
        rst  = 1'b0;
        #1;
        chk("rst_rdata0", 64'(rdata0), 64'(0));
        chk("rst_rdata1", 64'(rdata1), 64'(0));
        chk("rst_mem_addr", 64'(mem_addr), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_gnt0", 64'(gnt0), 64'(0));
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("rst_rvalid", 64'({rvalid1, rvalid0}), 64'(0));
        end
        @(posedge clk);
        #3 rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("rst_rvalid_after", 64'({rvalid1, rvalid0}), 64'(0));
        end

        // Tie held after reset: grants alternate 0,1,0,1 two cycles apart.
        req0 = 1'b1; req1 = 1'b1; addr0 = 9'h041; addr1 = 9'h042;
        for (int c = 0; c < 16; c++) begin
            tick();
            if (gnt0 === 1'b1) begin order.push_back(0); at.push_back(c); end
            if (gnt1 === 1'b1) begin order.push_back(1); at.push_back(c); end
            if (order.size() == 4) break;
        end
        req0 = 1'b0; req1 = 1'b0;
        chk("tie_count", 64'(order.size()), 64'(4));
        for (int j = 0; j < order.size(); j++) begin
            chk("tie_order", 64'(order[j]), 64'(j % 2));
            if (j > 0) chk("tie_gap", 64'(at[j] - at[j-1]), 64'(2));
        end
        repeat (4) tick();
        chk("tie_rdata0", 64'(rdata0), 64'(32'h4100_BE00));
        chk("tie_rdata1", 64'(rdata1), 64'(32'h4200_BD00));

        // Port 1 back-to-back for four grants.
        req1 = 1'b1; addr1 = 9'h130;
        gc = 0; vc = 0; last_at = -1;
        for (int c = 0; c < 24; c++) begin
            tick();
            if (rvalid1 === 1'b1) vc++;
            if (vc == 4) break;
            if (gnt1 === 1'b1) begin
                gc++;
                if (last_at >= 0) chk("b2b_gap", 64'(c - last_at), 64'(2));
                last_at = c;
                if (gc == 4) req1 = 1'b0;
            end
            if (gc > 0) chk("b2b_busy", 64'(busy), 64'(1));
        end
        req1 = 1'b0;
        chk("b2b_gnts", 64'(gc), 64'(4));
        chk("b2b_rvalids", 64'(vc), 64'(4));
        chk("b2b_rdata0", 64'(rdata0), 64'(32'h4100_BE00));
        chk("b2b_rdata1", 64'(rdata1), 64'(32'h3000_CF00));

        // Port 1 raises and withdraws while a port-0 read is in the address phase.
        tick();
        req0 = 1'b1; addr0 = 9'h020;
        wait_any_gnt(ok);
        chk("wd_gnt0", 64'(gnt0), 64'(1));
        req0 = 1'b0; req1 = 1'b1; addr1 = 9'h055;
        tick();
        req1 = 1'b0;
        chk("wd_busy_read", 64'(busy), 64'(1));
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("wd_gnt1", 64'(gnt1), 64'(0));
        end
        chk("wd_busy_idle", 64'(busy), 64'(0));

        // Random traffic against fresh key-state contents.
        for (int i = 0; i < 256; i++) key_mem[i] = $urandom;
        target = reads + 10000;
        cyc = 0;
        while (reads < target && cyc < 40000) begin
            @(negedge clk);
            g0 = gnt0; g1 = gnt1;
            @(posedge clk);
            #1;
            cyc++;
            if (req0) begin
                if (g0) begin
                    if ($urandom_range(0, 3) != 0) addr0 = AW'($urandom_range(0, 511));
                    else req0 = 1'b0;
                end else if ($urandom_range(0, 15) == 0) begin
                    req0 = 1'b0;
                end
            end else if ($urandom_range(0, 2) == 0) begin
                req0 = 1'b1; addr0 = AW'($urandom_range(0, 511));
            end
            if (req1) begin
                if (g1) begin
                    if ($urandom_range(0, 3) != 0) addr1 = AW'($urandom_range(0, 511));
                    else req1 = 1'b0;
                end else if ($urandom_range(0, 15) == 0) begin
                    req1 = 1'b0;
                end
            end else if ($urandom_range(0, 2) == 0) begin
                req1 = 1'b1; addr1 = AW'($urandom_range(0, 511));
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        chk("rnd_reads_done", 64'(reads >= target), 64'(1));
        repeat (6) tick();
        chk("rnd_q0_drained", 64'(exp_q0.size()), 64'(0));
        chk("rnd_q1_drained", 64'(exp_q1.size()), 64'(0));
        chk("rnd_idle", 64'(busy), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
